// File: rtl/move_sequencer.sv
// move_sequencer: FIFO-buffered stepper move issuer using the drivers' go/steps/done handshake, with position tracking.
// Define BOUNDARY_ABORT_EN to make boundary events raise a sticky fault that flushes and blocks the queue.
module move_sequencer #(
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int POS_W         = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   input  logic                    cmd_dir,
   input  logic [11:0]             cmd_steps,
   output logic                    cmd_ready,
   output logic                    fwd_go,
   output logic                    bwd_go,
   output logic [11:0]             move_steps,
   input  logic                    fwd_done,
   input  logic                    bwd_done,
   input  logic                    boundary,
   output logic                    busy,
   output logic signed [POS_W-1:0] pos,
   output logic                    pos_valid,
   output logic                    fault
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, RELEASE, SETTLE} state_e;

   state_e                  state_q, state_d;
   logic [12:0]             mem_q [DEPTH];
   logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]             count_q, count_d;
   logic                    dir_q, dir_d;
   logic [11:0]             steps_q, steps_d;
   logic [SW-1:0]           cnt_q, cnt_d;
   logic signed [POS_W-1:0] pos_q, pos_d;
   logic                    pos_valid_q, pos_valid_d;
   logic                    push, pop, flush;
   logic [12:0]             head;

`ifdef BOUNDARY_ABORT_EN
   logic fault_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) fault_q <= 1'b0;
      else fault_q <= flush;
   // A boundary outside an active move, or at the end of one, aborts the whole queue.
   assign flush     = fault_q || (boundary && (state_q == IDLE || state_q == RELEASE || state_q == SETTLE));
   assign fault     = fault_q;
   assign cmd_ready = (count_q != FULL) && !fault_q;
`else
   assign flush     = 1'b0;
   assign fault     = 1'b0;
   assign cmd_ready = count_q != FULL;
`endif

   assign push = cmd_valid && cmd_ready && !flush;
   assign pop  = state_q == LOAD;
   assign head = mem_q[rd_q];

   always_comb begin
      state_d     = state_q;
      wr_d        = push ? wr_q + 1'b1 : wr_q;
      rd_d        = pop ? rd_q + 1'b1 : rd_q;
      count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      dir_d       = dir_q;
      steps_d     = steps_q;
      cnt_d       = cnt_q + 1'b1;
      pos_d       = pos_q;
      pos_valid_d = pos_valid_q;
      case (state_q)
         IDLE:    state_d = (count_q != '0 && !flush) ? LOAD : IDLE;
         LOAD: begin
            dir_d   = head[12];
            steps_d = head[11:0];
            state_d = (head[11:0] == '0) ? IDLE : RUN;
         end
         RUN:     state_d = (dir_q ? fwd_done : bwd_done) ? RELEASE : RUN;
         RELEASE: begin
            cnt_d       = '0;
            pos_d       = boundary ? pos_q : dir_q ? pos_q + POS_W'(steps_q) : pos_q - POS_W'(steps_q);
            pos_valid_d = pos_valid_q && !boundary;
            state_d     = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
         end
         SETTLE:  state_d = (cnt_q == SETTLE_LAST) ? IDLE : SETTLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         wr_d    = wr_q;
         rd_d    = wr_q;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         dir_q       <= 1'b0;
         steps_q     <= '0;
         cnt_q       <= '0;
         pos_q       <= '0;
         pos_valid_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         dir_q       <= dir_d;
         steps_q     <= steps_d;
         cnt_q       <= cnt_d;
         pos_q       <= pos_d;
         pos_valid_q <= pos_valid_d;
      end

   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= {cmd_dir, cmd_steps};

   // go is decoded from the state register so an async reset drops it immediately.
   assign fwd_go     = (state_q == RUN) && dir_q;
   assign bwd_go     = (state_q == RUN) && !dir_q;
   assign move_steps = steps_q;
   assign busy       = (count_q != '0) || (state_q != IDLE);
   assign pos        = pos_q;
   assign pos_valid  = pos_valid_q;
endmodule
